// File: rtl/regfile_dump_unit.sv
// ---------------------------------------------------------------------------
// regfile_dump_unit
//
// Register-file dump engine. On request it walks the core register file
// through a debug read port. It streams every entry out as an {index, value}
// beat to a host/UART bridge. It holds cpu_stall while busy so that the
// register contents cannot change during the dump.
//
// Ports
//   clk, reset      system clock; synchronous active-high reset
//   dump_start      request a dump (sampled only while idle)
//   dump_abort      cancel an in-progress dump (also wins over dump_start)
//   rf_rd_en/addr   debug read-port enable and index (active only in READ)
//   rf_rd_data      debug read-port data, combinational from rf_rd_addr
//   out_valid/ready beat handshake toward the sink
//   out_idx/data    register index and value of the current beat
//   busy, cpu_stall dump in progress (state != IDLE)
//   done            one-cycle pulse after the last beat is accepted
//   state_dbg       current FSM state (0 IDLE, 1 READ, 2 SEND, 3 DONE)
//
// Handshake: a beat transfers on a rising edge where out_valid and out_ready
// are both 1. Once out_valid rises, out_valid, out_idx and out_data are held
// stable until that transfer. The only exceptions are abort and reset, which
// withdraw the beat. out_valid never depends combinationally on out_ready.
// ---------------------------------------------------------------------------
module regfile_dump_unit #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 5,
  parameter int SKIP_X0  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dump_start,
  input  logic              dump_abort,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [XLEN-1:0]   rf_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [XLEN-1:0]   out_data,
  output logic              busy,
  output logic              cpu_stall,
  output logic              done,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] FIRST_IDX = (SKIP_X0 != 0) ? ADDR_W'(1) : '0;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic              handshake;
  logic              start_ok;

  assign handshake = out_valid & out_ready;
  // Abort wins over a simultaneous start while idle.
  assign start_ok  = dump_start & ~dump_abort;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_ok) state_nxt = S_READ;
      S_READ: state_nxt = dump_abort ? S_IDLE : S_SEND;
      S_SEND: begin
        if (dump_abort)     state_nxt = S_IDLE;
        else if (handshake) state_nxt = (idx == LAST_IDX) ? S_DONE : S_READ;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: walk index and the registered beat. The beat is captured once
  // in READ. Later rf_rd_data changes therefore cannot disturb a pending beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
    end else if (state == S_IDLE) begin
      if (start_ok) idx <= FIRST_IDX;
    end else if (dump_abort) begin
      // A beat that handshakes in this cycle has already been delivered.
      // Dropping valid only removes a beat that has not been accepted.
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_READ: begin
          out_data  <= rf_rd_data;
          out_idx   <= idx;
          out_valid <= 1'b1;
        end
        S_SEND: begin
          if (handshake) begin
            out_valid <= 1'b0;
            // No wrap: the walk ends on the compare against LAST_IDX.
            if (idx != LAST_IDX) idx <= idx + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    rf_rd_en   = (state == S_READ);
    rf_rd_addr = (state == S_READ) ? idx : '0;
    busy       = (state != S_IDLE);
    cpu_stall  = (state != S_IDLE);
    done       = (state == S_DONE);
    state_dbg  = state;
  end

endmodule

// File: tb/tb_regfile_dump_unit.sv
module tb_regfile_dump_unit;

  localparam int XLEN     = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, dump_start, dump_abort, out_ready, sel;
  logic [XLEN-1:0] regfile [NUM_REGS];

  // dut0: SKIP_X0=0, dut1: SKIP_X0=1. The sel signal routes start/abort to one DUT and picks its outputs.
  logic              rf_rd_en_0, rf_rd_en_1;
  logic [ADDR_W-1:0] rf_rd_addr_0, rf_rd_addr_1;
  logic [XLEN-1:0]   rf_rd_data_0, rf_rd_data_1;
  logic              out_valid_0, out_valid_1;
  logic [ADDR_W-1:0] out_idx_0, out_idx_1;
  logic [XLEN-1:0]   out_data_0, out_data_1;
  logic              busy_0, busy_1, cpu_stall_0, cpu_stall_1, done_0, done_1;
  logic [1:0]        state_dbg_0, state_dbg_1;
  logic              start_0, start_1, abort_0, abort_1;

  assign start_0 = dump_start & ~sel;
  assign start_1 = dump_start & sel;
  assign abort_0 = dump_abort & ~sel;
  assign abort_1 = dump_abort & sel;
  assign rf_rd_data_0 = regfile[rf_rd_addr_0];
  assign rf_rd_data_1 = regfile[rf_rd_addr_1];

  regfile_dump_unit #(.NUM_REGS(NUM_REGS), .XLEN(XLEN), .ADDR_W(ADDR_W), .SKIP_X0(0)) dut0 (
    .clk(clk), .reset(reset), .dump_start(start_0), .dump_abort(abort_0),
    .rf_rd_en(rf_rd_en_0), .rf_rd_addr(rf_rd_addr_0), .rf_rd_data(rf_rd_data_0),
    .out_valid(out_valid_0), .out_ready(out_ready), .out_idx(out_idx_0), .out_data(out_data_0),
    .busy(busy_0), .cpu_stall(cpu_stall_0), .done(done_0), .state_dbg(state_dbg_0)
  );

  regfile_dump_unit #(.NUM_REGS(NUM_REGS), .XLEN(XLEN), .ADDR_W(ADDR_W), .SKIP_X0(1)) dut1 (
    .clk(clk), .reset(reset), .dump_start(start_1), .dump_abort(abort_1),
    .rf_rd_en(rf_rd_en_1), .rf_rd_addr(rf_rd_addr_1), .rf_rd_data(rf_rd_data_1),
    .out_valid(out_valid_1), .out_ready(out_ready), .out_idx(out_idx_1), .out_data(out_data_1),
    .busy(busy_1), .cpu_stall(cpu_stall_1), .done(done_1), .state_dbg(state_dbg_1)
  );

  logic              rf_rd_en, out_valid, busy, cpu_stall, done;
  logic [ADDR_W-1:0] rf_rd_addr, out_idx;
  logic [XLEN-1:0]   out_data;
  logic [1:0]        state_dbg;
  assign rf_rd_en   = sel ? rf_rd_en_1   : rf_rd_en_0;
  assign rf_rd_addr = sel ? rf_rd_addr_1 : rf_rd_addr_0;
  assign out_valid  = sel ? out_valid_1  : out_valid_0;
  assign out_idx    = sel ? out_idx_1    : out_idx_0;
  assign out_data   = sel ? out_data_1   : out_data_0;
  assign busy       = sel ? busy_1       : busy_0;
  assign cpu_stall  = sel ? cpu_stall_1  : cpu_stall_0;
  assign done       = sel ? done_1       : done_0;
  assign state_dbg  = sel ? state_dbg_1  : state_dbg_0;

  int errors = 0;
  int checks = 0;

  // Advance one cycle; sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reset ----------------
  task automatic test_reset();
    sel = 1'b0; reset = 1'b1; dump_start = 1'b1; dump_abort = 1'b0; out_ready = 1'b0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    checks++; if (out_idx !== '0) begin errors++; $display("FAIL reset out_idx got %0d want 0", out_idx); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset out_data got %h want 0", out_data); end
    checks++; if (busy !== 1'b0 || cpu_stall !== 1'b0) begin errors++; $display("FAIL reset busy/stall got %b/%b want 0/0", busy, cpu_stall); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done got %b want 0", done); end
    checks++; if (rf_rd_en !== 1'b0 || rf_rd_addr !== '0) begin errors++; $display("FAIL reset rf_rd got %b/%0d want 0/0", rf_rd_en, rf_rd_addr); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset state got %0d want 0", state_dbg); end
    checks++; if (busy_1 !== 1'b0 || out_valid_1 !== 1'b0) begin errors++; $display("FAIL reset dut1 busy/valid got %b/%b want 0/0", busy_1, out_valid_1); end
    reset = 1'b0; dump_start = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset start_ignored busy got %b want 0", busy); end
  endtask

  // ---------------- generic dump with scoreboard ----------------
  // first: first index expected; stall_beat/stall_len: hold out_ready low
  // for stall_len cycles while that beat is valid; poke_beat: pulse
  // dump_start while that beat is valid (-1 = none).
  task automatic run_dump(input string name, input int first, input int stall_beat,
                          input int stall_len, input int poke_beat);
    logic [ADDR_W+XLEN-1:0] exp_q[$];
    logic [ADDR_W+XLEN-1:0] exp;
    int n, cyc, stall_total, stall_cnt, beat_no, done_cnt, done_cyc;
    logic expect_read, held, finished;
    logic [ADDR_W-1:0] h_idx;
    logic [XLEN-1:0]   h_data;
    for (int i = first; i < NUM_REGS; i++) exp_q.push_back({ADDR_W'(i), regfile[i]});
    n = exp_q.size();
    cyc = 1; stall_total = 0; stall_cnt = 0; beat_no = 0; done_cnt = 0; done_cyc = -1;
    expect_read = 1'b1; held = 1'b0; finished = 1'b0; h_idx = '0; h_data = '0;
    sel = (first == 1);
    out_ready = 1'b1; dump_start = 1'b1;
    step();
    while (!finished && cyc <= 400) begin
      dump_start = 1'b0;
      if (poke_beat >= 0 && out_valid && out_idx == ADDR_W'(poke_beat)) dump_start = 1'b1;
      out_ready = 1'b1;
      if (stall_cnt < stall_len && out_valid && out_idx == ADDR_W'(stall_beat)) begin
        out_ready = 1'b0; stall_cnt++;
      end
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out_idx !== h_idx || out_data !== h_data) begin
          errors++;
          $display("FAIL %s hold cyc %0d got v=%b %0d/%h want v=1 %0d/%h", name, cyc, out_valid, out_idx, out_data, h_idx, h_data);
        end
      end
      checks++;
      if (cpu_stall !== busy) begin errors++; $display("FAIL %s stall_eq_busy cyc %0d got %b want %b", name, cyc, cpu_stall, busy); end
      checks++;
      if (rf_rd_en !== expect_read) begin errors++; $display("FAIL %s rf_rd_en cyc %0d got %b want %b", name, cyc, rf_rd_en, expect_read); end
      else if (expect_read && rf_rd_addr !== exp_q[0][ADDR_W+XLEN-1:XLEN]) begin
        errors++; $display("FAIL %s rf_rd_addr cyc %0d got %0d want %0d", name, cyc, rf_rd_addr, exp_q[0][ADDR_W+XLEN-1:XLEN]);
      end else if (!expect_read && rf_rd_addr !== '0) begin
        errors++; $display("FAIL %s rf_rd_addr_idle cyc %0d got %0d want 0", name, cyc, rf_rd_addr);
      end
      held = 1'b0;
      if (out_valid && !out_ready) begin
        held = 1'b1; h_idx = out_idx; h_data = out_data; stall_total++;
      end
      expect_read = 1'b0;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s extra_beat cyc %0d got idx %0d want none", name, cyc, out_idx);
        end else begin
          exp = exp_q.pop_front();
          if ({out_idx, out_data} !== exp) begin
            errors++; $display("FAIL %s beat cyc %0d got %0d/%h want %0d/%h", name, cyc, out_idx, out_data, exp[ADDR_W+XLEN-1:XLEN], exp[XLEN-1:0]);
          end
          checks++;
          if (cyc != 2 + 2 * beat_no + stall_total) begin
            errors++; $display("FAIL %s beat_time idx %0d got cyc %0d want %0d", name, out_idx, cyc, 2 + 2 * beat_no + stall_total);
          end
          beat_no++;
          expect_read = (exp_q.size() != 0);
        end
      end
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (busy !== 1'b1) finished = 1'b1;
      else begin step(); cyc++; end
    end
    dump_start = 1'b0; out_ready = 1'b1;
    checks++; if (!finished) begin errors++; $display("FAIL %s timeout got busy at cyc %0d want idle", name, cyc); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL %s missing_beats got %0d left want 0", name, exp_q.size()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s done_count got %0d want 1", name, done_cnt); end
    checks++; if (done_cyc != 2 + 2 * (n - 1) + stall_total + 1) begin errors++; $display("FAIL %s done_time got %0d want %0d", name, done_cyc, 2 + 2 * (n - 1) + stall_total + 1); end
    checks++; if (cyc != 2 + 2 * (n - 1) + stall_total + 2) begin errors++; $display("FAIL %s busy_end got idle at %0d want %0d", name, cyc, 2 + 2 * (n - 1) + stall_total + 2); end
    step();
  endtask

  // ---------------- abort / reset while beat 10 is pending ----------------
  task automatic test_abort(input bit use_reset);
    int guard;
    logic found;
    sel = 1'b0; out_ready = 1'b1; dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    found = 1'b0; guard = 0;
    while (!found && guard < 100) begin
      if (out_valid && out_idx == ADDR_W'(10)) found = 1'b1;
      else begin step(); guard++; end
    end
    checks++; if (!found) begin errors++; $display("FAIL abort reach_beat10 got timeout want beat 10"); end
    out_ready = 1'b0;
    if (use_reset) reset = 1'b1; else dump_abort = 1'b1;
    step();
    reset = 1'b0; dump_abort = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort(rst=%0d) after got v/busy/done %b/%b/%b want 0/0/0", use_reset, out_valid, busy, done);
    end
    if (use_reset) begin
      checks++; if (out_idx !== '0 || out_data !== '0) begin
        errors++; $display("FAIL reset_mid outputs got %0d/%h want 0/0", out_idx, out_data);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL abort(rst=%0d) quiet cyc %0d got done/busy %b/%b want 0/0", use_reset, i, done, busy);
      end
    end
    out_ready = 1'b1;
  endtask

  // ---------------- start+abort together in IDLE ----------------
  task automatic test_abort_start_idle();
    sel = 1'b0; dump_start = 1'b1; dump_abort = 1'b1;
    step();
    dump_start = 1'b0; dump_abort = 1'b0;
    checks++; if (busy !== 1'b0 || rf_rd_en !== 1'b0) begin
      errors++; $display("FAIL abort_start_idle got busy/rd_en %b/%b want 0/0", busy, rf_rd_en);
    end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_idle later got busy %b want 0", busy); end
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) regfile[i] = 32'h1000_0000 + 32'(i);
    test_reset();
    run_dump("full", 0, -1, 0, -1);
    run_dump("backpressure", 0, 3, 5, -1);
    run_dump("skip_x0", 1, -1, 0, -1);
    test_abort(1'b0);
    run_dump("restart_after_abort", 0, -1, 0, -1);
    test_abort(1'b1);
    run_dump("restart_after_reset", 0, -1, 0, -1);
    test_abort_start_idle();
    run_dump("start_while_busy", 0, -1, 0, 5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
